// File: rtl/lfsr_beam_emulator_if.sv
// Request/status bundle between a self-test controller and the LFSR beam emulator.
// The controller drives the burst request; the emulator answers with busy/done/error.
interface lfsr_beam_emulator_if;
    logic        start;
    logic        poly_sel;
    logic [16:0] seed;
    logic [15:0] burst_len;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, poly_sel, seed, burst_len,
        input  busy, done, error
    );

    modport slave (
        input  start, poly_sel, seed, burst_len,
        output busy, done, error
    );
endinterface

// File: rtl/lfsr_beam_emulator.sv
// Transmit-side model of the sweep bitstream: a BMC-encoded LFSR burst on one of two
// base-station polynomials, with a free-running timestamp and first-bit timestamp capture.
module lfsr_beam_emulator #(
    parameter int          HALF_BIT   = 6,
    parameter int          GAP_CYCLES = 16,
    parameter logic [23:0] TS_INIT    = 24'h000000
) (
    input  logic                 clk_72MHz,
    input  logic                 rst_n,
    lfsr_beam_emulator_if.slave  ctl,
    output logic                 bmc_out,
    output logic                 envelope,
    output logic [23:0]          ts_now,
    output logic [23:0]          ts_first,
    output logic [16:0]          lfsr_state,
    output logic [15:0]          bits_sent
);

    localparam logic [16:0] POLY0      = 17'h1d258;
    localparam logic [16:0] POLY1      = 17'h17e04;
    localparam int          BIT_CYCLES = 2 * HALF_BIT;
    localparam int          CNT_MAX    = (GAP_CYCLES > BIT_CYCLES) ? GAP_CYCLES : BIT_CYCLES;
    localparam int          CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] MID_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_TX,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [16:0]       poly_q, poly_d;
    logic [15:0]       len_q, len_d;
    logic [16:0]       lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              bmc_q, bmc_d;
    logic              env_q, env_d;
    logic [23:0]       ts_q, ts_d;
    logic [23:0]       ts_first_q, ts_first_d;
    logic [15:0]       bits_q, bits_d;

    function automatic logic [16:0] lfsr_next(input logic [16:0] s, input logic [16:0] p);
        return {s[15:0], ^(s & p)};
    endfunction

    always_comb begin
        state_d    = state_q;
        poly_d     = poly_q;
        len_d      = len_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        bmc_d      = bmc_q;
        env_d      = env_q;
        ts_first_d = ts_first_q;
        bits_d     = bits_q;
        ts_d       = ts_q + 24'd1;

        unique case (state_q)
            S_IDLE: begin
                if (ctl.start) begin
                    poly_d  = ctl.poly_sel ? POLY1 : POLY0;
                    lfsr_d  = ctl.seed;
                    len_d   = ctl.burst_len;
                    busy_d  = 1'b1;
                    bits_d  = 16'd0;
                    cnt_d   = '0;
                    error_d = (ctl.seed == 17'd0);
                    // An all-zero seed would lock the LFSR, so it is refused outright.
                    if ((ctl.seed == 17'd0) || (ctl.burst_len == 16'd0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d    = S_TX;
                    env_d      = 1'b1;
                    ts_first_d = ts_q;
                    bmc_d      = ~bmc_q;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_TX: begin
                if (cnt_q == MID_LAST) begin
                    // Mid-bit transition encodes a 1; the bit on air is the LFSR MSB.
                    if (lfsr_q[16]) begin
                        bmc_d = ~bmc_q;
                    end
                    cnt_d = cnt_q + CNT_ONE;
                end else if (cnt_q == BIT_LAST) begin
                    lfsr_d = lfsr_next(lfsr_q, poly_q);
                    bits_d = bits_q + 16'd1;
                    cnt_d  = '0;
                    if (bits_q == (len_q - 16'd1)) begin
                        env_d   = 1'b0;
                        bmc_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        bmc_d = ~bmc_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_72MHz) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            poly_q     <= '0;
            len_q      <= '0;
            lfsr_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            bmc_q      <= 1'b0;
            env_q      <= 1'b0;
            ts_q       <= TS_INIT;
            ts_first_q <= '0;
            bits_q     <= '0;
        end else begin
            state_q    <= state_d;
            poly_q     <= poly_d;
            len_q      <= len_d;
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            bmc_q      <= bmc_d;
            env_q      <= env_d;
            ts_q       <= ts_d;
            ts_first_q <= ts_first_d;
            bits_q     <= bits_d;
        end
    end

    assign ctl.busy   = busy_q;
    assign ctl.done   = done_q;
    assign ctl.error  = error_q;
    assign bmc_out    = bmc_q;
    assign envelope   = env_q;
    assign ts_now     = ts_q;
    assign ts_first   = ts_first_q;
    assign lfsr_state = lfsr_q;
    assign bits_sent  = bits_q;

endmodule

// File: tb/tb_lfsr_beam_emulator.sv
// Self-checking bench for lfsr_beam_emulator: expected bits are queued when a burst is
// requested and compared as the BMC line is decoded.
module tb_lfsr_beam_emulator;

    localparam int          HB     = 6;
    localparam int          GAP    = 16;
    localparam logic [16:0] P0     = 17'h1d258;
    localparam logic [16:0] P1     = 17'h17e04;
    localparam logic [23:0] W_INIT = 24'hfffff0;

    logic        clk_72MHz = 1'b0;
    logic        rst_n     = 1'b0;
    logic        bmc_out, envelope;
    logic [23:0] ts_now, ts_first;
    logic [16:0] lfsr_state;
    logic [15:0] bits_sent;
    logic        w_bmc, w_env;
    logic [23:0] w_ts_now, w_ts_first;
    logic [16:0] w_lfsr;
    logic [15:0] w_bits;

    int n_chk  = 0;
    int n_fail = 0;
    bit exp_q[$];

    lfsr_beam_emulator_if m_if ();
    lfsr_beam_emulator_if w_if ();

    lfsr_beam_emulator dut (
        .clk_72MHz (clk_72MHz),
        .rst_n     (rst_n),
        .ctl       (m_if),
        .bmc_out   (bmc_out),
        .envelope  (envelope),
        .ts_now    (ts_now),
        .ts_first  (ts_first),
        .lfsr_state(lfsr_state),
        .bits_sent (bits_sent)
    );

    lfsr_beam_emulator #(.TS_INIT(W_INIT)) dut_wrap (
        .clk_72MHz (clk_72MHz),
        .rst_n     (rst_n),
        .ctl       (w_if),
        .bmc_out   (w_bmc),
        .envelope  (w_env),
        .ts_now    (w_ts_now),
        .ts_first  (w_ts_first),
        .lfsr_state(w_lfsr),
        .bits_sent (w_bits)
    );

    always #5 clk_72MHz = ~clk_72MHz;

    function automatic logic [16:0] model_step(input logic [16:0] s, input logic [16:0] p);
        return {s[15:0], ^(s & p)};
    endfunction

    // BMC decoder / scoreboard consumer for the main instance.
    int          ph = 0;
    int          stray = 0;
    logic        prev_bmc = 1'b0;
    logic        prev_env = 1'b0;
    logic        lvl0 = 1'b0;
    logic [23:0] prev_ts = 24'd0;

    always @(negedge clk_72MHz) begin
        int   p;
        bit   e;
        logic got;
        if (envelope === 1'b1) begin
            if (prev_env !== 1'b1) begin
                ph = 0;
                n_chk++;
                if (ts_first !== prev_ts) begin
                    n_fail++;
                    $display("FAIL ts_first got %h want %h", ts_first, prev_ts);
                end
            end
            p = ph % (2 * HB);
            if (p == 0) begin
                if (bmc_out === prev_bmc) stray++;
                lvl0 = bmc_out;
            end else if (p == HB) begin
                got = bmc_out ^ lvl0;
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_bit index %0d got %b want none", ph / (2 * HB), got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL bit_value index %0d got %b want %b", ph / (2 * HB), got, e);
                    end
                end
                n_chk++;
                if (bits_sent !== 16'(ph / (2 * HB))) begin
                    n_fail++;
                    $display("FAIL bits_sent_live got %0d want %0d", bits_sent, ph / (2 * HB));
                end
            end else if (bmc_out !== prev_bmc) begin
                stray++;
            end
            ph++;
        end
        prev_bmc = bmc_out;
        prev_env = envelope;
        prev_ts  = ts_now;
    end

    task automatic drive_start(input logic sel, input logic [16:0] sd, input logic [15:0] len,
                               output logic [16:0] fin);
        logic [16:0] s;
        s = sd;
        if (sd != 17'd0) begin
            for (int i = 0; i < int'(len); i++) begin
                exp_q.push_back(s[16]);
                s = model_step(s, sel ? P1 : P0);
            end
        end
        fin = s;
        m_if.poly_sel  = sel;
        m_if.seed      = sd;
        m_if.burst_len = len;
        m_if.start     = 1'b1;
        @(negedge clk_72MHz);
        m_if.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit poke, output int cyc,
                             output bit busy_drop, output bit env_seen);
        cyc = -1;
        busy_drop = 1'b0;
        env_seen = 1'b0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk_72MHz);
            if (envelope === 1'b1) env_seen = 1'b1;
            if (m_if.done === 1'b1) begin
                cyc = k;
                break;
            end
            if (m_if.busy !== 1'b1) busy_drop = 1'b1;
            if (poke && (k % 10 == 5)) begin
                m_if.start     = 1'b1;
                m_if.poly_sel  = 1'b1;
                m_if.seed      = 17'h1ffff;
                m_if.burst_len = 16'd9;
            end else begin
                m_if.start = 1'b0;
            end
        end
        m_if.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_72MHz);
        n_chk++;
        if ({m_if.busy, m_if.done, m_if.error, bmc_out, envelope} !== 5'b0 ||
            ts_now !== 24'd0 || ts_first !== 24'd0 || lfsr_state !== 17'd0 || bits_sent !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy%b done%b err%b bmc%b env%b ts%h tsf%h lfsr%h bits%0d want all 0",
                     m_if.busy, m_if.done, m_if.error, bmc_out, envelope, ts_now, ts_first, lfsr_state, bits_sent);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_72MHz);
            n_chk++;
            if (ts_now !== 24'(i)) begin
                n_fail++;
                $display("FAIL ts_count got %h want %h", ts_now, 24'(i));
            end
        end
    endtask

    task automatic test_zero_run();
        logic [16:0] fin;
        int cyc;
        bit bd, es;
        stray = 0;
        drive_start(1'b0, 17'h00001, 16'd17, fin);
        n_chk++;
        if (m_if.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_busy_accept got %b want 1", m_if.busy);
        end
        wait_done(400, 1'b0, cyc, bd, es);
        n_chk++;
        if (cyc !== 1 + GAP + 17 * 2 * HB + 1) begin
            n_fail++;
            $display("FAIL t1_done_latency got %0d want %0d", cyc, 1 + GAP + 17 * 2 * HB + 1);
        end
        n_chk++;
        if (bd || m_if.busy !== 1'b0 || m_if.error !== 1'b0 || envelope !== 1'b0 || bmc_out !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_done_flags got drop%b busy%b err%b env%b bmc%b want 0 0 0 0 0",
                     bd, m_if.busy, m_if.error, envelope, bmc_out);
        end
        n_chk++;
        if (lfsr_state !== fin || bits_sent !== 16'd17) begin
            n_fail++;
            $display("FAIL t1_final got lfsr %h bits %0d want lfsr %h bits 17", lfsr_state, bits_sent, fin);
        end
        n_chk++;
        if (exp_q.size() != 0 || stray != 0) begin
            n_fail++;
            $display("FAIL t1_stream got leftover %0d stray %0d want 0 0", exp_q.size(), stray);
        end
        @(negedge clk_72MHz);
        n_chk++;
        if (m_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_done_pulse got %b want 0", m_if.done);
        end
    endtask

    task automatic test_all_ones();
        logic [16:0] fin;
        int cyc;
        bit bd, es;
        stray = 0;
        drive_start(1'b1, 17'h1ffff, 16'd3, fin);
        wait_done(200, 1'b0, cyc, bd, es);
        n_chk++;
        if (cyc !== 1 + GAP + 3 * 2 * HB + 1) begin
            n_fail++;
            $display("FAIL t2_done_latency got %0d want %0d", cyc, 1 + GAP + 3 * 2 * HB + 1);
        end
        n_chk++;
        if (lfsr_state !== fin || bits_sent !== 16'd3) begin
            n_fail++;
            $display("FAIL t2_final got lfsr %h bits %0d want lfsr %h bits 3", lfsr_state, bits_sent, fin);
        end
        n_chk++;
        if (exp_q.size() != 0 || stray != 0) begin
            n_fail++;
            $display("FAIL t2_stream got leftover %0d stray %0d want 0 0", exp_q.size(), stray);
        end
        @(negedge clk_72MHz);
    endtask

    task automatic test_seed_zero();
        logic [16:0] fin;
        int cyc;
        bit bd, es;
        drive_start(1'b0, 17'h00000, 16'd5, fin);
        n_chk++;
        if (m_if.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_busy_accept got %b want 1", m_if.busy);
        end
        wait_done(10, 1'b0, cyc, bd, es);
        n_chk++;
        if (cyc !== 1 || m_if.error !== 1'b1 || m_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_reject got cyc %0d err %b busy %b want 1 1 0", cyc, m_if.error, m_if.busy);
        end
        n_chk++;
        if (es !== 1'b0 || envelope !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_envelope got %b want 0", es | envelope);
        end
        repeat (3) @(negedge clk_72MHz);
        n_chk++;
        if (m_if.error !== 1'b1 || m_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_error_hold got err %b done %b want 1 0", m_if.error, m_if.done);
        end
    endtask

    task automatic test_len_zero();
        logic [16:0] fin;
        int cyc;
        bit bd, es;
        drive_start(1'b1, 17'h00abc, 16'd0, fin);
        n_chk++;
        if (m_if.error !== 1'b0) begin
            n_fail++;
            $display("FAIL t_len0_error_clear got %b want 0", m_if.error);
        end
        wait_done(10, 1'b0, cyc, bd, es);
        n_chk++;
        if (cyc !== 1 || es !== 1'b0 || m_if.error !== 1'b0 || bits_sent !== 16'd0 || lfsr_state !== fin) begin
            n_fail++;
            $display("FAIL t_len0 got cyc %0d env %b err %b bits %0d lfsr %h want 1 0 0 0 %h",
                     cyc, es, m_if.error, bits_sent, lfsr_state, fin);
        end
        @(negedge clk_72MHz);
    endtask

    task automatic test_wrap();
        logic [23:0] exp_ts;
        bit seen;
        int k;
        rst_n = 1'b0;
        repeat (2) @(negedge clk_72MHz);
        rst_n = 1'b1;
        w_if.poly_sel  = 1'b0;
        w_if.seed      = 17'h00001;
        w_if.burst_len = 16'd1;
        w_if.start     = 1'b1;
        seen = 1'b0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk_72MHz);
            w_if.start = 1'b0;
            exp_ts = W_INIT + 24'(k + 1);
            n_chk++;
            if (w_ts_now !== exp_ts) begin
                n_fail++;
                $display("FAIL t4_ts_now got %h want %h", w_ts_now, exp_ts);
            end
            if (w_env === 1'b1 && !seen) begin
                seen = 1'b1;
                n_chk++;
                if (w_ts_first !== W_INIT + 24'(GAP + 1)) begin
                    n_fail++;
                    $display("FAIL t4_ts_first got %h want %h", w_ts_first, W_INIT + 24'(GAP + 1));
                end
            end
            if (w_if.done === 1'b1) break;
        end
        n_chk++;
        if (!seen || k != 1 + GAP + 2 * HB + 1) begin
            n_fail++;
            $display("FAIL t4_burst got env_seen %b done_at %0d want 1 %0d", seen, k, 1 + GAP + 2 * HB + 1);
        end
        @(negedge clk_72MHz);
    endtask

    task automatic test_reset_mid();
        logic [16:0] fin;
        int cyc;
        bit bd, es, hit;
        drive_start(1'b1, 17'h12345, 16'd40, fin);
        hit = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_72MHz);
            if (bits_sent === 16'd5) begin
                hit = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL t5_reach_bit5 got bits %0d want 5", bits_sent);
        end
        rst_n = 1'b0;
        @(negedge clk_72MHz);
        n_chk++;
        if ({m_if.busy, m_if.done, m_if.error, bmc_out, envelope} !== 5'b0 ||
            ts_now !== 24'd0 || ts_first !== 24'd0 || lfsr_state !== 17'd0 || bits_sent !== 16'd0) begin
            n_fail++;
            $display("FAIL t5_abort got busy%b done%b err%b bmc%b env%b ts%h tsf%h lfsr%h bits%0d want all 0",
                     m_if.busy, m_if.done, m_if.error, bmc_out, envelope, ts_now, ts_first, lfsr_state, bits_sent);
        end
        rst_n = 1'b1;
        exp_q.delete();
        stray = 0;
        drive_start(1'b0, 17'h0beef, 16'd2, fin);
        n_chk++;
        if (m_if.busy !== 1'b1 || m_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_restart got busy %b done %b want 1 0", m_if.busy, m_if.done);
        end
        wait_done(200, 1'b0, cyc, bd, es);
        n_chk++;
        if (cyc !== 1 + GAP + 2 * 2 * HB + 1 || lfsr_state !== fin || exp_q.size() != 0 || stray != 0) begin
            n_fail++;
            $display("FAIL t5_second_burst got cyc %0d lfsr %h left %0d stray %0d want %0d %h 0 0",
                     cyc, lfsr_state, exp_q.size(), stray, 1 + GAP + 2 * 2 * HB + 1, fin);
        end
        @(negedge clk_72MHz);
    endtask

    task automatic test_start_while_busy();
        logic [16:0] fin;
        int cyc;
        bit bd, es;
        stray = 0;
        drive_start(1'b0, 17'h0a5a5, 16'd4, fin);
        wait_done(300, 1'b1, cyc, bd, es);
        n_chk++;
        if (cyc !== 1 + GAP + 4 * 2 * HB + 1 || bd) begin
            n_fail++;
            $display("FAIL t6_latency got cyc %0d busy_drop %b want %0d 0", cyc, bd, 1 + GAP + 4 * 2 * HB + 1);
        end
        n_chk++;
        if (lfsr_state !== fin || bits_sent !== 16'd4 || exp_q.size() != 0 || stray != 0) begin
            n_fail++;
            $display("FAIL t6_stream got lfsr %h bits %0d left %0d stray %0d want %h 4 0 0",
                     lfsr_state, bits_sent, exp_q.size(), stray, fin);
        end
        repeat (3) @(negedge clk_72MHz);
        n_chk++;
        if (m_if.busy !== 1'b0 || envelope !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_no_queue got busy %b env %b want 0 0", m_if.busy, envelope);
        end
    endtask

    initial begin
        m_if.start = 1'b0; m_if.poly_sel = 1'b0; m_if.seed = '0; m_if.burst_len = '0;
        w_if.start = 1'b0; w_if.poly_sel = 1'b0; w_if.seed = '0; w_if.burst_len = '0;
        test_reset();
        test_zero_run();
        test_all_ones();
        test_seed_zero();
        test_len_zero();
        test_wrap();
        test_reset_mid();
        test_start_while_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
